aes_round_ctrl: RTL and testbench

//   Sequences the iterative AES-128/192/256 encryption datapath: one transform
//   per cycle (sub_bytes, shift_rows, mix_columns, add_round_key) on a shared
//   128-bit state register. Drives the datapath op-select, state write enable
//   and round counter, and handshakes round keys with the key schedule.

---
 rtl/aes_round_ctrl.sv | 68 ++++++
 tb/tb_aes_round_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences the iterative AES round datapath one transform per cycle
// and handshakes round keys with the key schedule.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_start,
    input  logic       i_key_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_load,
    output logic [1:0] o_op,
    output logic       o_state_we,
    output logic [3:0] o_round,
    output logic       o_key_req
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ARK   = 3'd2;
    localparam logic [2:0] SUB   = 3'd3;
    localparam logic [2:0] SHIFT = 3'd4;
    localparam logic [2:0] MIX   = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;
    localparam logic [3:0] LAST  = 4'(NUM_ROUNDS);

    logic [2:0] state, next;
    logic [3:0] round;
    logic       last;

    assign last = round == LAST;

    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = i_start ? LOAD : IDLE;
            LOAD:    next = ARK;
            SUB:     next = SHIFT;
            SHIFT:   next = last ? ARK : MIX;
            MIX:     next = ARK;
            ARK:     next = !i_key_ready ? ARK : last ? DONE : SUB;
            default: next = IDLE;
        endcase
    end

    // Counter clears whenever the FSM lands in IDLE, so illegal states also restart it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            round <= 4'd0;
        end else begin
            state <= next;
            if (next == IDLE || state == LOAD)
                round <= 4'd0;
            else if (state == ARK && i_key_ready && !last)
                round <= round + 4'd1;
        end
    end

    assign o_busy     = state != IDLE;
    assign o_done     = state == DONE;
    assign o_load     = state == LOAD;
    assign o_op       = state == SHIFT ? 2'd1 : state == MIX ? 2'd2 : state == ARK ? 2'd3 : 2'd0;
    assign o_state_we = (state == LOAD) || (state == SUB) || (state == SHIFT) || (state == MIX) ||
                        (state == ARK && i_key_ready);
    assign o_round    = round;
    assign o_key_req  = state == ARK;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboarded cycle trace of two controller instances (Nr=10, Nr=14)
// plus an AES-128 datapath model that checks the FIPS-197 ciphertext on each done.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic start_a = 1'b0, kr_a = 1'b0, start_b = 1'b0, kr_b = 1'b0;
    logic a_busy, a_done, a_load, a_we, a_kreq, b_busy, b_done, b_load, b_we, b_kreq;
    logic [1:0] a_op, b_op;
    logic [3:0] a_round, b_round;
    logic [10:0] va, vb;
    logic [10:0] exp_q[$];
    logic [127:0] dp;
    logic [127:0] rk[0:10];
    logic [31:0] w[0:43];
    int checks = 0, errors = 0;

    localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(10)) dut_a (
        .clk(clk), .n_rst(n_rst), .i_start(start_a), .i_key_ready(kr_a),
        .o_busy(a_busy), .o_done(a_done), .o_load(a_load), .o_op(a_op),
        .o_state_we(a_we), .o_round(a_round), .o_key_req(a_kreq)
    );
    aes_round_ctrl #(.NUM_ROUNDS(14)) dut_b (
        .clk(clk), .n_rst(n_rst), .i_start(start_b), .i_key_ready(kr_b),
        .o_busy(b_busy), .o_done(b_done), .o_load(b_load), .o_op(b_op),
        .o_state_we(b_we), .o_round(b_round), .o_key_req(b_kreq)
    );

    assign va = {a_busy, a_done, a_load, a_op, a_we, a_round, a_kreq};
    assign vb = {b_busy, b_done, b_load, b_op, b_we, b_round, b_kreq};

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] y = 8'h01;
        repeat (254) y = gm(y, a);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sb(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [10:0] ev(input logic busy, input logic done, input logic load,
                                       input logic [1:0] op, input logic we, input int round,
                                       input logic kreq);
        return {busy, done, load, op, we, 4'(round), kreq};
    endfunction

    // Datapath model driven only by the Nr=10 controller's select outputs.
    always @(posedge clk)
        if (a_we)
            dp <= a_load ? PT : a_op == 2'd0 ? sub_bytes(dp) : a_op == 2'd1 ? shift_rows(dp) :
                  a_op == 2'd2 ? mix_columns(dp) : dp ^ rk[a_round];

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(11'd0);
    endtask

    task automatic push_run(input int nr, input int wr, input int wn);
        exp_q.push_back(ev(1, 0, 1, 2'd0, 1, 0, 0));
        for (int r = 0; r <= nr; r++) begin
            if (r > 0) begin
                exp_q.push_back(ev(1, 0, 0, 2'd0, 1, r, 0));
                exp_q.push_back(ev(1, 0, 0, 2'd1, 1, r, 0));
                if (r < nr) exp_q.push_back(ev(1, 0, 0, 2'd2, 1, r, 0));
            end
            if (r == wr) repeat (wn) exp_q.push_back(ev(1, 0, 0, 2'd3, 0, r, 1));
            exp_q.push_back(ev(1, 0, 0, 2'd3, 1, r, 1));
        end
        exp_q.push_back(ev(1, 1, 0, 2'd0, 0, nr, 0));
    endtask

    task automatic step(input string tag, input bit sel, input bit st, input bit kr);
        logic [10:0] obs, e;
        @(negedge clk);
        start_a = sel ? 1'b0 : st;
        kr_a    = sel ? 1'b0 : kr;
        start_b = sel ? st : 1'b0;
        kr_b    = sel ? kr : 1'b0;
        #1;
        obs = sel ? vb : va;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s trace: observed %h expected %h at %0t", tag, obs, e, $time);
        end
        if (!sel && a_done) begin
            checks++;
            assert (dp === CT) else begin
                errors++;
                $error("FAIL %s ciphertext: observed %h expected %h", tag, dp, CT);
            end
        end
    endtask

    initial begin
        logic [31:0] t;
        logic [7:0] rc;
        int n;
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb(t[31:24]) ^ rc, sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        repeat (2) @(negedge clk);
        checks += 2;
        assert (va === 11'd0) else begin errors++; $error("FAIL reset_a: observed %h expected %h", va, 11'd0); end
        assert (vb === 11'd0) else begin errors++; $error("FAIL reset_b: observed %h expected %h", vb, 11'd0); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        push_idle(1); push_run(10, -1, 0); push_idle(2);
        n = exp_q.size();
        for (int k = 0; k < n; k++) step("nr10_basic", 0, k == 0, 1'b1);

        push_idle(1); push_run(10, 4, 3); push_idle(2);
        n = exp_q.size();
        for (int k = 0; k < n; k++) step("key_wait", 0, k == 0, !(k >= 18 && k <= 20));

        push_idle(1); push_run(14, -1, 0); push_idle(2);
        n = exp_q.size();
        for (int k = 0; k < n; k++) step("nr14", 1, k == 0, 1'b1);

        push_idle(1); push_run(10, -1, 0); push_idle(1); push_run(10, -1, 0); push_idle(2);
        n = exp_q.size();
        for (int k = 0; k < n; k++) step("start_held", 0, k <= 43, 1'b1);

        push_idle(1); push_run(10, -1, 0);
        for (int k = 0; k <= 24; k++) step("pre_reset", 0, k == 0, 1'b1);
        exp_q.delete();
        n_rst = 1'b0;
        #1;
        checks++;
        assert (va === 11'd0) else begin errors++; $error("FAIL async_reset: observed %h expected %h", va, 11'd0); end
        @(negedge clk);
        n_rst = 1'b1;
        push_idle(50);
        for (int k = 0; k < 50; k++) step("post_reset_idle", 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
